mult_result_writer: RTL

- Capture side of the multiplier datapath. Operand fetch reads pairs from the 32x64 operand bank and drives one product per cycle, tagged with a 2-bit mode.
- This block accepts those tagged products through a valid/ready handshake and normalises each to 64 bits per its mode.
- Stored results go into a result RAM with an address counter, fill tracking and overflow detection.
- A registered read-back port lets the test harness or host drain the results.

---
 rtl/mult_result_writer_pkg.sv | 46 ++++
 rtl/mult_result_writer_result_ram.sv | 37 +++
 rtl/mult_result_writer.sv | 106 ++++++++++
 3 files changed

// File: rtl/mult_result_writer_pkg.sv
// rtl/mult_result_writer_pkg.sv - shared mode tags, FSM states, result entry type, normaliser
//
// Contents:
//   RES_DEPTH/RES_ADDR_W/RES_DATA_W  default geometry of the result store
//   M1..M4                           product mode tags (also used by operand fetch)
//   state_t                          capture FSM states
//   result_entry_t                   stored {mode, normalised data}
//   normalise()                      widen a raw product to RES_DATA_W per its mode
package mult_result_writer_pkg;

   localparam int RES_DEPTH  = 16;
   localparam int RES_ADDR_W = 4;
   localparam int RES_DATA_W = 64;

   // Mode tags: unsigned 8x8, signed 8x8, signed 16x16, 32x32
   localparam logic [1:0] M1 = 2'd0;
   localparam logic [1:0] M2 = 2'd1;
   localparam logic [1:0] M3 = 2'd2;
   localparam logic [1:0] M4 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0]            mode;
      logic [RES_DATA_W-1:0] data;
   } result_entry_t;

   // 8x8 products occupy 16 bits, 16x16 products 32 bits; 32x32 is already full width.
   function automatic logic [RES_DATA_W-1:0] normalise(input logic [1:0]            mode,
                                                       input logic [RES_DATA_W-1:0] product);
      logic [RES_DATA_W-1:0] res;
      res = product;
      case (mode)
         M1:      res = {{(RES_DATA_W-16){1'b0}}, product[15:0]};
         M2:      res = {{(RES_DATA_W-16){product[15]}}, product[15:0]};
         M3:      res = {{(RES_DATA_W-32){product[31]}}, product[31:0]};
         default: res = product;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mult_result_writer_result_ram.sv
// rtl/mult_result_writer_result_ram.sv - result store, sync write, registered read-before-write read
//
// Ports:
//   clock    in   rising-edge clock
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   entry to store
//   rd_en    in   read strobe; rd_data updates on the following edge
//   rd_addr  in   read index
//   rd_data  out  registered read data (old contents on a same-address write)
module result_ram #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int WIDTH  = 66
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // No reset: stale contents are hidden by the read-error gating in the top.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/mult_result_writer.sv
// rtl/mult_result_writer.sv - capture tagged multiplier products into a result RAM with read-back
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   start               clear count/flags and arm capture (beats on this edge are dropped)
//   in_valid/in_ready   product handshake; ready only while armed
//   in_mode, in_product mode tag and raw product
//   wr_count, full      entries written since start; full when DEPTH reached
//   overflow            sticky: beat offered while full
//   rd_en, rd_addr      read request
//   rd_valid, rd_data,  one-cycle-later response; data/mode zeroed when
//   rd_mode, rd_err     rd_addr was not below wr_count at request time
module mult_result_writer
   import mult_result_writer_pkg::*;
#(
   parameter int DEPTH  = RES_DEPTH,
   parameter int ADDR_W = RES_ADDR_W,
   parameter int DATA_W = RES_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [1:0]        in_mode,
   input  logic [DATA_W-1:0] in_product,
   output logic              in_ready,
   output logic [ADDR_W:0]   wr_count,
   output logic              full,
   output logic              overflow,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [1:0]        rd_mode,
   output logic              rd_err
);

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

   state_t        state;
   logic          accept;
   result_entry_t wr_entry;
   result_entry_t ram_q;

   assign in_ready = (state == ST_ARMED);
   assign full     = (state == ST_FULL);
   assign accept   = in_valid && in_ready && !start;

   assign wr_entry.mode = in_mode;
   assign wr_entry.data = normalise(in_mode, in_product);

   result_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  ($bits(result_entry_t))
   ) u_ram (
      .clock   (clock),
      .wr_en   (accept),
      .wr_addr (wr_count[ADDR_W-1:0]),
      .wr_data (wr_entry),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (ram_q)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         wr_count <= '0;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         // Compared against the pre-write count, so the slot being written this edge is an error.
         rd_err   <= rd_en && ({1'b0, rd_addr} >= wr_count);
         if (start) begin
            state    <= ST_ARMED;
            wr_count <= '0;
            overflow <= 1'b0;
         end else begin
            case (state)
               ST_ARMED: begin
                  if (in_valid) begin
                     wr_count <= wr_count + 1'b1;
                     if (wr_count == LAST_IDX) begin
                        state <= ST_FULL;
                     end
                  end
               end
               ST_FULL: begin
                  if (in_valid) begin
                     overflow <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Gating also keeps the response at zero out of reset, since the RAM register is not reset.
   assign rd_data = (rd_valid && !rd_err) ? ram_q.data : '0;
   assign rd_mode = (rd_valid && !rd_err) ? ram_q.mode : 2'd0;

endmodule
